mem_fifo_ctrl: RTL and testbench
================================

Name: mem_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the single-port `memory` block (clk, wr, rd, addr, bidirectional data).
- Turns a producer push handshake and a consumer pop request into `memory` wr/rd/addr/data bus cycles.
- Storage lives entirely in the external `memory`; this block holds only pointers, occupancy count, FSM and the bus driver.
- Gives the team a 2**AWIDTH-entry buffer without duplicating storage.

Parameters:
- AWIDTH, 5, `memory` address width; FIFO depth is 2**AWIDTH.
- DWIDTH, 8, data width; must match `memory`.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has in_data to push.
- in_ready  output  1  push accepted on a rising edge where in_valid && in_ready.
- in_data  input  DWIDTH  push data.
- pop_req  input  1  consumer requests one entry (level).
- out_valid  output  1  one-cycle pulse; out_data holds the popped entry.
- out_data  output  DWIDTH  last popped data; held until the next pop completes.
- full  output  1  count == 2**AWIDTH.
- empty  output  1  count == 0.
- count  output  AWIDTH+1  current occupancy.
- wr  output  1  to `memory` wr.
- rd  output  1  to `memory` rd.
- addr  output  AWIDTH  to `memory` addr.
- data  inout  DWIDTH  `memory` data bus; driven only in WRITE, otherwise 'bz.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wptr=rptr=0; count=0; wr=rd=0; addr=0; data released to 'bz.
  - out_valid=0; out_data=0; last_op=READ (so the first tie goes to the write).
  - `memory` contents are not cleared; the FIFO reads as empty.
  - Reset mid-WRITE or mid-READ aborts the operation with no pointer or count change.
- FSM states: IDLE, WRITE, READ1, READ2. wr and rd are never both 1.
- Arbitration in IDLE:
  - wcand = in_valid && !full; rcand = pop_req && !empty.
  - Tie (both asserted): grant the op opposite last_op.
  - in_ready = (state==IDLE) && !full && !(rcand && last_op==WRITE); combinational.
  - in_ready is 0 in every other state.
- Write path:
  - Push accepted: in_data registered; IDLE->WRITE; last_op=WRITE.
  - WRITE (one cycle): wr=1, addr=wptr, data=registered word.
  - End of WRITE: wptr+=1 (wraps mod 2**AWIDTH), count+=1, ->IDLE.
  - Push throughput: one per 2 cycles.
- Read path:
  - Pop granted: IDLE->READ1; last_op=READ.
  - READ1 and READ2: rd=1, addr=rptr, data='bz.
  - Rising edge ending READ2: out_data<=data, rptr+=1 (wraps), count-=1, ->IDLE.
  - out_valid=1 for the following cycle only.
  - The two-cycle rd window tolerates either combinational or registered `memory` read.
  - Pop throughput: one per 3 cycles.
- Boundaries:
  - full blocks pushes; empty ignores pop_req (no bus activity).
  - count never over- or underflows.
  - Pointer wrap 31->0 is transparent.
  - pop_req held high yields back-to-back pops, out_valid every 3rd cycle.
  - A push during READ1/READ2 sees in_ready=0; the producer holds its data.
- Outputs full, empty and count are decoded from the registered count.

Decomposition:
- Shared package mem_pkg:
  - state encoding localparams (IDLE, WRITE, READ1, READ2);
  - op encoding for last_op;
  - default AWIDTH/DWIDTH constants, also used by `memory` and its bench.
- One natural sub-module: mem_fifo_ptr, holding wptr, rptr and count with inc_w/inc_r strobes and full/empty decode.
- FSM, arbiter and bus driver stay in mem_fifo_ctrl.

Test Plan:
- Bench setup: instantiate mem_fifo_ctrl together with `memory`, AWIDTH=5, DWIDTH=8.
- Reset then single push 8'hA5, then pop_req -> wr pulses with addr=0, data=A5; later rd high 2 cycles at addr=0; out_valid pulse with out_data=A5; empty=1, count=0.
- Push 32 words 0..31 with in_valid held -> full=1 and count=32 after the 32nd WRITE; in_ready stays 0; a 33rd word is not written (no wr).
- Pop all 32 with pop_req held -> out_data sequence 0..31, out_valid every 3rd cycle, empty=1 at end; further pop_req produces no rd.
- Wrap: push 20, pop 20, push 20 (values 8'h40+i), pop 20 -> writes at addr 20..31 then 0..7; pops return 40..53 in order.
- Simultaneous in_valid and pop_req with count=4 -> grants alternate, read first (last_op=WRITE after the fills), then write, then read; data order preserved.
- Assert rst_n low during READ2, then release -> rd=0, data='bz, out_valid=0, count=0, empty=1; the next push lands at addr=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and default geometry for the FIFO controller and the
// single-port memory it fronts.
package mem_pkg;

  localparam int MEM_AWIDTH = 5;
  localparam int MEM_DWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ1 = 2'd2,
    ST_READ2 = 2'd3
  } state_e;

  // last_op decides who wins when push and pop arrive together
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// Producer/consumer handshake, status and memory control lines of the FIFO
// controller. The tristate data bus stays a plain port on the controller.
interface mem_fifo_ctrl_if #(
  parameter int AWIDTH = mem_pkg::MEM_AWIDTH,
  parameter int DWIDTH = mem_pkg::MEM_DWIDTH
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              pop_req;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              full;
  logic              empty;
  logic [AWIDTH:0]   count;
  logic              wr;
  logic              rd;
  logic [AWIDTH-1:0] addr;

  modport slave (
    input  in_valid, in_data, pop_req,
    output in_ready, out_valid, out_data, full, empty, count, wr, rd, addr
  );

  modport master (
    output in_valid, in_data, pop_req,
    input  in_ready, out_valid, out_data, full, empty, count, wr, rd, addr
  );
endinterface

// File: rtl/mem_fifo_ptr.sv
// Write/read pointers and occupancy count for a memory-backed FIFO.
// Strobes that would over- or underflow the count are dropped.
module mem_fifo_ptr #(
  parameter int AWIDTH = mem_pkg::MEM_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_w_i,
  input  logic              inc_r_i,
  output logic [AWIDTH-1:0] wptr_o,
  output logic [AWIDTH-1:0] rptr_o,
  output logic [AWIDTH:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              do_w, do_r;

  // MSB of the count is set only at exactly 2**AWIDTH entries
  assign full_o  = count_q[AWIDTH];
  assign empty_o = (count_q == '0);
  assign do_w    = inc_w_i && !full_o;
  assign do_r    = inc_r_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q + AWIDTH'(do_w);
    rptr_d  = rptr_q + AWIDTH'(do_r);
    count_d = count_q;
    if (do_w && !do_r)      count_d = count_q + 1'b1;
    else if (do_r && !do_w) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a single-port memory: arbitrates push/pop,
// sequences one-cycle writes and two-cycle reads, drives the shared data bus.
module mem_fifo_ctrl
  import mem_pkg::*;
#(
  parameter int AWIDTH = MEM_AWIDTH,
  parameter int DWIDTH = MEM_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_fifo_ctrl_if.slave    bus,
  inout  wire  [DWIDTH-1:0] data
);

  state_e            state_q;
  op_e               last_op_q;
  logic [DWIDTH-1:0] wdata_q, out_data_q;
  logic              wr_q, rd_q, out_valid_q;
  logic [AWIDTH-1:0] addr_q;

  logic [AWIDTH-1:0] wptr, rptr;
  logic [AWIDTH:0]   count;
  logic              full, empty;
  logic              idle, wcand, rcand, grant_w, grant_r;

  mem_fifo_ptr #(.AWIDTH(AWIDTH)) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_w_i (state_q == ST_WRITE),
    .inc_r_i (state_q == ST_READ2),
    .wptr_o  (wptr),
    .rptr_o  (rptr),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // On a tie the op opposite the previous one wins, so neither side starves
  always_comb begin
    idle    = (state_q == ST_IDLE);
    wcand   = bus.in_valid && !full;
    rcand   = bus.pop_req && !empty;
    grant_w = idle && wcand && (!rcand || last_op_q == OP_READ);
    grant_r = idle && rcand && (!wcand || last_op_q == OP_WRITE);
  end

  assign bus.in_ready  = idle && !full && !(rcand && last_op_q == OP_WRITE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.wr        = wr_q;
  assign bus.rd        = rd_q;
  assign bus.addr      = addr_q;

  assign data = (state_q == ST_WRITE) ? wdata_q : {DWIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_op_q   <= OP_READ;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_w) begin
            state_q   <= ST_WRITE;
            last_op_q <= OP_WRITE;
            wdata_q   <= bus.in_data;
            wr_q      <= 1'b1;
            addr_q    <= wptr;
          end else if (grant_r) begin
            state_q   <= ST_READ1;
            last_op_q <= OP_READ;
            rd_q      <= 1'b1;
            addr_q    <= rptr;
          end
        end
        ST_WRITE: begin
          wr_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_READ1: state_q <= ST_READ2;
        ST_READ2: begin
          // two rd cycles give a registered memory time to present its word
          rd_q        <= 1'b0;
          out_data_q  <= data;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl with a behavioural memory on the shared bus and a
// queue-based transaction model checked every cycle.
module tb_mem_fifo_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire [DW-1:0] data;

  mem_fifo_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .data  (data)
  );

  always #5 clk = ~clk;

  // single-port memory, combinational read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.wr) mem[bus.addr] <= data;
  assign data = bus.rd ? mem[bus.addr] : {DW{1'bz}};

  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: contents, pointers, remaining bus cycles of the current op
  logic [DW-1:0] mq[$];
  logic [DW-1:0] got[$];
  int            wr_addrs[$];
  int            m_wptr, m_rptr, m_busy;
  bit            m_kind_w, m_last_w, m_ov;
  logic [DW-1:0] m_wdata, m_od;

  always @(negedge clk) begin
    bit exp_wr, exp_rd, exp_ir, wc, rc, gw, gr;
    if (!rst_n) begin
      mq.delete();
      m_wptr = 0; m_rptr = 0; m_busy = 0;
      m_kind_w = 0; m_last_w = 0; m_ov = 0; m_od = '0; m_wdata = '0;
      chk("rst_wr", bus.wr, 0);
      chk("rst_rd", bus.rd, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_ovalid", bus.out_valid, 0);
      chk("rst_odata", bus.out_data, 0);
    end else begin
      exp_wr = (m_busy > 0) && m_kind_w;
      exp_rd = (m_busy > 0) && !m_kind_w;
      exp_ir = (m_busy == 0) && (mq.size() < DEPTH) &&
               !(bus.pop_req && mq.size() > 0 && m_last_w);
      chk("wr", bus.wr, exp_wr);
      chk("rd", bus.rd, exp_rd);
      if (exp_wr) chk("waddr", bus.addr, m_wptr);
      if (exp_rd) chk("raddr", bus.addr, m_rptr);
      if (exp_wr) chk("wdata", data, m_wdata);
      chk("in_ready", bus.in_ready, exp_ir);
      chk("count", bus.count, mq.size());
      chk("full", bus.full, mq.size() == DEPTH);
      chk("empty", bus.empty, mq.size() == 0);
      chk("out_valid", bus.out_valid, m_ov);
      chk("out_data", bus.out_data, m_od);
      if (bus.out_valid) got.push_back(bus.out_data);
      if (bus.wr) wr_addrs.push_back(int'(bus.addr));
      // advance to the next cycle
      m_ov = 0;
      if (m_busy > 0) begin
        if (m_kind_w) begin
          mq.push_back(m_wdata);
          m_wptr = (m_wptr + 1) % DEPTH;
          m_busy = 0;
        end else if (m_busy == 2) begin
          m_busy = 1;
        end else begin
          m_od = mq.pop_front();
          m_ov = 1;
          m_rptr = (m_rptr + 1) % DEPTH;
          m_busy = 0;
        end
      end else begin
        wc = bus.in_valid && mq.size() < DEPTH;
        rc = bus.pop_req && mq.size() > 0;
        gw = wc && (!rc || !m_last_w);
        gr = rc && (!wc || m_last_w);
        if (gw) begin m_busy = 1; m_kind_w = 1; m_wdata = bus.in_data; m_last_w = 1; end
        else if (gr) begin m_busy = 2; m_kind_w = 0; m_last_w = 0; end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.pop_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    sync();
    bus.in_valid = 1'b1; bus.in_data = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (++n > 100) begin
        tests++; failed++;
        $display("FAIL push_timeout: in_ready never seen, required 1");
        break;
      end
    end
    sync();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin @(negedge clk); k++; end
    tests++;
    if (got.size() < n) begin
      failed++;
      $display("FAIL pop_timeout: got %0d pops, required %0d", got.size(), n);
    end
  endtask

  task automatic pop_n(input int n);
    got.delete();
    sync(); bus.pop_req = 1'b1;
    wait_got(n, 3 * n + 20);
    sync(); bus.pop_req = 1'b0;
  endtask

  initial begin
    bit acc;
    int k;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.pop_req = 1'b0;
    do_reset();

    // single push/pop of A5
    wr_addrs.delete();
    push(8'hA5);
    pop_n(1);
    if (got.size() > 0) chk("t1_data", got[0], 8'hA5);
    if (wr_addrs.size() > 0) chk("t1_waddr", wr_addrs[0], 0);
    @(negedge clk);
    chk("t1_count", bus.count, 0);
    chk("t1_empty", bus.empty, 1);

    // fill to 32, then a 33rd word is refused
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    repeat (2) @(negedge clk);
    chk("t2_full", bus.full, 1);
    chk("t2_count", bus.count, 32);
    k = wr_addrs.size();
    sync(); bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    repeat (6) @(negedge clk);
    chk("t2_ir", bus.in_ready, 0);
    chk("t2_no_wr", wr_addrs.size() - k, 0);
    sync(); bus.in_valid = 1'b0;

    // drain with pop_req held; extra cycles must show no rd
    got.delete();
    sync(); bus.pop_req = 1'b1;
    wait_got(DEPTH, 3 * DEPTH + 20);
    repeat (10) @(negedge clk);
    sync(); bus.pop_req = 1'b0;
    for (int i = 0; i < DEPTH && i < got.size(); i++) chk("t3_order", got[i], i);
    chk("t3_empty", bus.empty, 1);

    // pointer wrap
    do_reset();
    wr_addrs.delete();
    for (int i = 0; i < 20; i++) push(8'(i));
    pop_n(20);
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    pop_n(20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("t4_data", got[i], 8'h40 + i);
    chk("t4_nwr", wr_addrs.size(), 40);
    for (int i = 0; i < 40 && i < wr_addrs.size(); i++) chk("t4_waddr", wr_addrs[i], i % DEPTH);

    // simultaneous push and pop with 4 stored: read wins first
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    got.delete();
    sync(); bus.in_valid = 1'b1; bus.in_data = 8'h80; bus.pop_req = 1'b1;
    @(negedge clk);
    chk("t5_ir", bus.in_ready, 0);
    @(negedge clk);
    chk("t5_first_rd", bus.rd, 1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      sync();
      if (acc) bus.in_data = bus.in_data + 8'd1;
    end
    bus.in_valid = 1'b0; bus.pop_req = 1'b0;
    if (got.size() > 1) begin
      chk("t5_pop0", got[0], 8'h10);
      chk("t5_pop1", got[1], 8'h11);
    end

    // reset in the middle of READ2
    push(8'h55); push(8'h56);
    sync(); bus.pop_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.rd && k < 50);
    @(negedge clk);
    #2 rst_n = 1'b0; bus.pop_req = 1'b0;
    @(negedge clk);
    chk("t6_rd", bus.rd, 0);
    chk("t6_ovalid", bus.out_valid, 0);
    chk("t6_count", bus.count, 0);
    chk("t6_empty", bus.empty, 1);
    sync(); rst_n = 1'b1;
    wr_addrs.delete();
    push(8'h77);
    repeat (2) @(negedge clk);
    chk("t6_nwr", wr_addrs.size(), 1);
    if (wr_addrs.size() > 0) chk("t6_waddr", wr_addrs[0], 0);

    // random traffic: push-heavy phase then pop-heavy phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        sync();
        if (!bus.in_valid || acc) begin
          bus.in_valid = $urandom_range(0, 99) < (ph == 0 ? 70 : 30);
          bus.in_data  = 8'($urandom);
        end
        bus.pop_req = $urandom_range(0, 99) < (ph == 0 ? 30 : 70);
      end
    end
    sync(); bus.in_valid = 1'b0; bus.pop_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
